debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 111 +++++++++++
 rtl/debounce_multi.sv | 49 ++++
 tb/tb_debounce_multi.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } deb_state_t;

  localparam int unsigned MIN_CHANNELS      = 1;
  localparam int unsigned MAX_CHANNELS      = 32;
  localparam int unsigned MIN_STABLE_CYCLES = 2;
  localparam int unsigned MIN_SYNC_STAGES   = 2;
  localparam int unsigned MAX_SYNC_STAGES   = 4;

  // Counter must be able to hold STABLE_CYCLES without wrapping.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability counter and four-state FSM.
// Optional rise/fall strobes are built when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2_000_000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic rise,
  output logic fall,
`endif
  output logic debounced
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam deb_state_t RST_STATE = INIT_LEVEL ? IDLE_HI : IDLE_LO;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  // Metastability synchroniser; oldest stage feeds the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      debounced <= INIT_LEVEL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      debounced <= (state_d == IDLE_HI) || (state_d == CHK_LO);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LO: begin
        if (sync) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!sync) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (sync) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  // Strobes fire only on a qualified transition, in step with debounced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (state_q == CHK_HI) && (state_d == IDLE_HI);
      fall <= (state_q == CHK_LO) && (state_d == IDLE_LO);
    end
  end
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: CHANNELS independent debounce_channel slices.
// Define DEBOUNCE_EDGE_PULSE_EN to add the rise/fall strobe ports.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 2_000_000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisy,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
`endif
  output logic [CHANNELS-1:0] debounced
);

  // Reject illegal configurations at elaboration.
  if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be in 1..32");
  end
  if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_stable
    $error("debounce_multi: STABLE_CYCLES must be at least 2");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be in 2..4");
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .INIT_LEVEL    (INIT_LEVEL)
    ) u_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .noisy     (noisy[i]),
`ifdef DEBOUNCE_EDGE_PULSE_EN
      .rise      (rise[i]),
      .fall      (fall[i]),
`endif
      .debounced (debounced[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (STABLE_CYCLES=16, SYNC_STAGES=2, 4 channels).
// Expected output events are queued with their cycle when stimulus is applied.
module tb_debounce_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned SC = 16;
  localparam int unsigned SS = 2;
  // Drive just after edge c -> first sampling edge c+1 -> output after edge c+1+SS+SC-1.
  localparam int LAT = SS + SC;

  typedef struct {
    int             cyc;
    logic [CH-1:0]  deb;
    logic [CH-1:0]  rs;
    logic [CH-1:0]  fl;
  } ev_t;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] noisy;
  logic [CH-1:0] debounced;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  int   cyc;
  int   passed;
  int   total;
  ev_t  sb[$];
  logic [CH-1:0] prev_deb;

  debounce_multi #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (SC),
    .SYNC_STAGES   (SS),
    .INIT_LEVEL    (1'b0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .noisy     (noisy),
`ifdef DEBOUNCE_EDGE_PULSE_EN
    .rise      (rise),
    .fall      (fall),
`endif
    .debounced (debounced)
  );

`ifndef DEBOUNCE_EDGE_PULSE_EN
  assign rise = '0;
  assign fall = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Any visible output activity must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_deb = debounced;
    end else if ((debounced !== prev_deb) || (rise !== '0) || (fall !== '0)) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_event: cycle %0d debounced=%b rise=%b fall=%b, expected no activity",
                 cyc, debounced, rise, fall);
      end else begin
        ev_t e;
        e = sb.pop_front();
        total++;
        if (cyc !== e.cyc)
          $display("FAIL event_cycle: got cycle %0d expected %0d", cyc, e.cyc);
        else passed++;
        total++;
        if (debounced !== e.deb)
          $display("FAIL event_debounced: got %b expected %b (cycle %0d)", debounced, e.deb, cyc);
        else passed++;
`ifdef DEBOUNCE_EDGE_PULSE_EN
        total++;
        if (rise !== e.rs)
          $display("FAIL event_rise: got %b expected %b (cycle %0d)", rise, e.rs, cyc);
        else passed++;
        total++;
        if (fall !== e.fl)
          $display("FAIL event_fall: got %b expected %b (cycle %0d)", fall, e.fl, cyc);
        else passed++;
`endif
      end
      prev_deb = debounced;
    end
  end

  task automatic step_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    noisy   = '0;
    #23;
    total++;
    if (debounced !== 4'b0000) $display("FAIL reset_debounced: got %b expected 0000", debounced);
    else passed++;
    total++;
    if (rise !== 4'b0000 || fall !== 4'b0000)
      $display("FAIL reset_strobes: got rise=%b fall=%b expected 0000/0000", rise, fall);
    else passed++;
    step_drive();
    reset_n = 1'b1;
    idle(5);
    total++;
    if (debounced !== 4'b0000) $display("FAIL idle_after_reset: got %b expected 0000", debounced);
    else passed++;
  endtask

  task automatic check_settled(input string name, input logic [CH-1:0] exp);
    total++;
    if (sb.size() != 0) $display("FAIL %s_pending: got %0d outstanding events expected 0", name, sb.size());
    else passed++;
    total++;
    if (debounced !== exp) $display("FAIL %s_level: got %b expected %b", name, debounced, exp);
    else passed++;
  endtask

  task automatic test_clean_step();
    noisy[0] = 1'b1;
    sb.push_back('{cyc + LAT, 4'b0001, 4'b0001, 4'b0000});
    idle(LAT + 10);
    check_settled("clean_step", 4'b0001);
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 20; t++) begin
      noisy[1] = ~noisy[1];
      idle(5);
    end
    noisy[1] = 1'b0;
    idle(LAT + 10);
    check_settled("bounce", 4'b0001);
  endtask

  task automatic test_near_threshold();
    int c;
    noisy[2] = 1'b1;
    idle(SC - 1);
    noisy[2] = 1'b0;
    idle(LAT + 10);
    check_settled("near_short", 4'b0001);
    c = cyc;
    noisy[2] = 1'b1;
    sb.push_back('{c + LAT, 4'b0101, 4'b0100, 4'b0000});
    idle(SC);
    noisy[2] = 1'b0;
    sb.push_back('{c + SC + LAT, 4'b0001, 4'b0000, 4'b0100});
    idle(SC + LAT + 10);
    check_settled("near_exact", 4'b0001);
  endtask

  task automatic test_release();
    noisy[0] = 1'b0;
    sb.push_back('{cyc + LAT, 4'b0000, 4'b0000, 4'b0001});
    idle(LAT + 10);
    check_settled("release", 4'b0000);
  endtask

  task automatic test_parallel();
    noisy = 4'b1111;
    sb.push_back('{cyc + LAT, 4'b1111, 4'b1111, 4'b0000});
    idle(LAT + 10);
    check_settled("parallel_up", 4'b1111);
    noisy = 4'b0000;
    sb.push_back('{cyc + LAT, 4'b0000, 4'b0000, 4'b1111});
    idle(LAT + 10);
    check_settled("parallel_down", 4'b0000);
  endtask

  task automatic test_reset_mid_count();
    noisy = 4'b1111;
    sb.push_back('{cyc + LAT, 4'b1111, 4'b1111, 4'b0000});
    idle(LAT + 10);
    check_settled("pre_reset", 4'b1111);
    // Channel 3 reaches count 8 in CHK_LO at edge drive+10.
    noisy = 4'b0111;
    repeat (SS + 8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (debounced !== 4'b0000) $display("FAIL async_reset_level: got %b expected 0000", debounced);
    else passed++;
    total++;
    if (rise !== 4'b0000 || fall !== 4'b0000)
      $display("FAIL async_reset_strobes: got rise=%b fall=%b expected 0000/0000", rise, fall);
    else passed++;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    sb.push_back('{cyc + LAT, 4'b0111, 4'b0111, 4'b0000});
    idle(LAT + 10);
    check_settled("post_reset", 4'b0111);
  endtask

  initial begin
    cyc      = 0;
    passed   = 0;
    total    = 0;
    prev_deb = '0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_near_threshold();
    test_release();
    test_parallel();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
